// File: rtl/gbar_responder_pkg.sv
// Shared definitions for the cluster global-barrier (gbar) bus:
// width derivation helper, default cluster sizing and the request and
// response payload structs that the core-side gbar bus also uses.
package gbar_responder_pkg;

    // Index width for a population of n items; never narrower than 1 bit.
    function automatic int gbar_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Default cluster sizing.
    localparam int GBAR_NUM_CORES    = 4;
    localparam int GBAR_NUM_BARRIERS = 8;
    localparam int GBAR_NC_WIDTH     = gbar_width(GBAR_NUM_CORES);
    localparam int GBAR_NB_WIDTH     = gbar_width(GBAR_NUM_BARRIERS);

    // Arrival request payload carried alongside a core's req_valid.
    typedef struct packed {
        logic [GBAR_NB_WIDTH-1:0] id;
        logic [GBAR_NC_WIDTH-1:0] size_m1;
    } gbar_req_t;

    // Release response broadcast back to every core.
    typedef struct packed {
        logic                     valid;
        logic [GBAR_NB_WIDTH-1:0] id;
    } gbar_rsp_t;

endpackage

// File: rtl/gbar_responder_rr_arbiter.sv
// gbar_rr_arbiter: generic round-robin arbiter. Grants the first active
// requester at or after the pointer (wrapping), and moves the pointer to
// the slot after the winner only when the grant is consumed (fire).
module gbar_rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [N-1:0]     requests,
    input  logic             fire,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] ptr_r;
    logic             found_s;
    int               cand_s;

    // Select the first requester at or after the pointer, wrapping around.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found_s   = 1'b0;
        cand_s    = 0;
        for (int k = 0; k < N; k++) begin
            cand_s = (int'(ptr_r) + k) % N;
            if (!found_s && requests[cand_s]) begin
                found_s       = 1'b1;
                grant[cand_s] = 1'b1;
                grant_idx     = IDX_W'(cand_s);
            end else begin
                // an earlier slot already won, or this slot is idle
            end
        end
    end

    // Move the pointer just past the winner, but only when the grant is taken.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_r <= '0;
        end else if (fire && found_s) begin
            if (grant_idx == IDX_W'(N - 1)) begin
                ptr_r <= '0;
            end else begin
                ptr_r <= grant_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/gbar_responder.sv
// gbar_responder: cluster-level global-barrier responder.
// Accepts one barrier-arrival request per cycle from NUM_CORES cores
// (round-robin), tracks a per-barrier arrival mask, and broadcasts a
// one-cycle registered release (rsp_valid/rsp_id) once enough distinct
// cores have arrived. Core identity is its port index.
// Optional build macro GBAR_PERF_EN adds perf_releases/perf_wait_cycles.
module gbar_responder
    import gbar_responder_pkg::*;
#(
    parameter int NUM_CORES     = GBAR_NUM_CORES,
    parameter int NUM_BARRIERS  = GBAR_NUM_BARRIERS,
`ifdef GBAR_PERF_EN
    parameter int PERF_CTR_BITS = 32,
`endif
    parameter int NC_WIDTH      = gbar_width(NUM_CORES),
    parameter int NB_WIDTH      = gbar_width(NUM_BARRIERS)
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NUM_CORES-1:0]          req_valid,
    input  logic [NUM_CORES*NB_WIDTH-1:0] req_id,
    input  logic [NUM_CORES*NC_WIDTH-1:0] req_size_m1,
    output logic [NUM_CORES-1:0]          req_ready,
    output logic                          rsp_valid,
    output logic [NB_WIDTH-1:0]           rsp_id,
    output logic                          busy
`ifdef GBAR_PERF_EN
    ,
    output logic [PERF_CTR_BITS-1:0]      perf_releases,
    output logic [PERF_CTR_BITS-1:0]      perf_wait_cycles
`endif
);

    localparam int CNT_W = NC_WIDTH + 1;

    logic [NUM_CORES-1:0] grant_s;
    logic [NC_WIDTH-1:0]  grant_idx_s;
    logic                 accept_s;

    logic [NB_WIDTH-1:0]  req_id_a   [NUM_CORES];
    logic [NC_WIDTH-1:0]  req_size_a [NUM_CORES];

    logic [NB_WIDTH-1:0]  acc_id_s;
    logic [NC_WIDTH-1:0]  acc_size_s;
    logic                 id_ok_s;
    logic [NUM_CORES-1:0] old_mask_s;
    logic [NUM_CORES-1:0] new_mask_s;
    logic [CNT_W-1:0]     cnt_s;
    logic [CNT_W-1:0]     need_s;
    logic                 release_s;

    logic [NUM_CORES-1:0] mask_r [NUM_BARRIERS];
    logic                 rsp_valid_r;
    logic [NB_WIDTH-1:0]  rsp_id_r;
    logic                 busy_s;

    // Any active request is granted this cycle; exactly one per cycle.
    assign accept_s = |req_valid;

    gbar_rr_arbiter #(
        .N     (NUM_CORES),
        .IDX_W (NC_WIDTH)
    ) u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .requests  (req_valid),
        .fire      (accept_s),
        .grant     (grant_s),
        .grant_idx (grant_idx_s)
    );

    // Split the flat per-core request buses into indexable arrays.
    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            req_id_a[i]   = req_id[i*NB_WIDTH +: NB_WIDTH];
            req_size_a[i] = req_size_m1[i*NC_WIDTH +: NC_WIDTH];
        end
    end

    // Merge the granted core into its barrier mask and decide on release.
    always_comb begin
        acc_id_s   = req_id_a[grant_idx_s];
        acc_size_s = req_size_a[grant_idx_s];
        id_ok_s    = (int'(acc_id_s) < NUM_BARRIERS);
        if (id_ok_s) begin
            old_mask_s = mask_r[acc_id_s];
        end else begin
            old_mask_s = '0;
        end
        // A repeated arrival ORs in an already-set bit, so it is idempotent.
        new_mask_s = old_mask_s | grant_s;
        cnt_s      = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            cnt_s = cnt_s + CNT_W'(new_mask_s[i]);
        end
        need_s    = {1'b0, acc_size_s} + CNT_W'(1);
        release_s = accept_s && id_ok_s && (cnt_s >= need_s);
    end

    // Per-barrier arrival masks: clear on release, otherwise accumulate.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int b = 0; b < NUM_BARRIERS; b++) begin
                mask_r[b] <= '0;
            end
        end else if (accept_s && id_ok_s) begin
            if (release_s) begin
                mask_r[acc_id_s] <= '0;
            end else begin
                mask_r[acc_id_s] <= new_mask_s;
            end
        end
    end

    // Registered one-cycle release broadcast; rsp_id holds its last value.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid_r <= 1'b0;
            rsp_id_r    <= '0;
        end else begin
            rsp_valid_r <= release_s;
            if (release_s) begin
                rsp_id_r <= acc_id_s;
            end
        end
    end

    // Busy while any barrier holds arrivals, and through the cycle its
    // release is being broadcast, so an episode reads busy end to end.
    always_comb begin
        busy_s = rsp_valid_r;
        for (int b = 0; b < NUM_BARRIERS; b++) begin
            busy_s = busy_s | (|mask_r[b]);
        end
    end

    // Nothing is accepted while reset is held.
    assign req_ready = grant_s & {NUM_CORES{reset_n}};
    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign busy      = busy_s;

`ifdef GBAR_PERF_EN
    logic [PERF_CTR_BITS-1:0] perf_rel_r;
    logic [PERF_CTR_BITS-1:0] perf_wait_r;

    // Count release pulses and busy cycles; both wrap on overflow.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_rel_r  <= '0;
            perf_wait_r <= '0;
        end else begin
            if (rsp_valid_r) begin
                perf_rel_r <= perf_rel_r + PERF_CTR_BITS'(1);
            end
            if (busy_s) begin
                perf_wait_r <= perf_wait_r + PERF_CTR_BITS'(1);
            end
        end
    end

    assign perf_releases    = perf_rel_r;
    assign perf_wait_cycles = perf_wait_r;
`endif

endmodule

// File: tb/tb_gbar_responder.sv
// Self-checking bench for gbar_responder (4 cores, 8 barriers).
// A set-based model predicts grants, releases and busy every cycle;
// directed scenarios also pin hand-computed literal expectations.
module tb_gbar_responder;

    localparam int NC  = 4;
    localparam int NB  = 8;
    localparam int NCW = 2;
    localparam int NBW = 3;

    logic              clk;
    logic              reset_n;
    logic [NC-1:0]     req_valid;
    logic [NC*NBW-1:0] req_id;
    logic [NC*NCW-1:0] req_size_m1;
    logic [NC-1:0]     req_ready;
    logic              rsp_valid;
    logic [NBW-1:0]    rsp_id;
    logic              busy;
`ifdef GBAR_PERF_EN
    logic [31:0]       perf_releases;
    logic [31:0]       perf_wait_cycles;
`endif

    int checks = 0;
    int errors = 0;

    gbar_responder #(
        .NUM_CORES    (NC),
        .NUM_BARRIERS (NB)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .req_valid        (req_valid),
        .req_id           (req_id),
        .req_size_m1      (req_size_m1),
        .req_ready        (req_ready),
        .rsp_valid        (rsp_valid),
        .rsp_id           (rsp_id),
        .busy             (busy)
`ifdef GBAR_PERF_EN
        ,
        .perf_releases    (perf_releases),
        .perf_wait_cycles (perf_wait_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit [NC-1:0] m_mask [NB];
    int          m_ptr;
    bit          m_rv;
    int          m_rid;

    // Round-robin: first requesting core at or after the core following the last grant.
    function automatic int m_pick();
        for (int k = 0; k < NC; k++) begin
            if (req_valid[(m_ptr + k) % NC]) return (m_ptr + k) % NC;
        end
        return -1;
    endfunction

    function automatic bit m_busy();
        bit r;
        r = m_rv;
        for (int b = 0; b < NB; b++) r = r | (m_mask[b] != '0);
        return r;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        int g, b, s;
        bit [NC-1:0] nm;
        if (!reset_n) begin
            for (int i = 0; i < NB; i++) m_mask[i] <= '0;
            m_ptr <= 0;
            m_rv  <= 1'b0;
            m_rid <= 0;
        end else begin
            g = m_pick();
            m_rv <= 1'b0;
            if (g >= 0) begin
                b  = int'(req_id[g*NBW +: NBW]);
                s  = int'(req_size_m1[g*NCW +: NCW]);
                nm = m_mask[b] | (4'b0001 << g);
                if ($countones(nm) >= s + 1) begin
                    m_mask[b] <= '0;
                    m_rv      <= 1'b1;
                    m_rid     <= b;
                end else begin
                    m_mask[b] <= nm;
                end
                m_ptr <= (g + 1) % NC;
            end
        end
    end

    // Compare the DUT against the model on every falling edge.
    always @(negedge clk) begin
        int p;
        logic [NC-1:0] er;
        p  = m_pick();
        er = '0;
        if (reset_n && p >= 0) er[p] = 1'b1;
        chk("model_req_ready", 32'(req_ready), 32'(er));
        chk("model_rsp_valid", 32'(rsp_valid), 32'(m_rv));
        if (m_rv) chk("model_rsp_id", 32'(rsp_id), 32'(m_rid));
        chk("model_busy", 32'(busy), 32'(m_busy()));
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input int c, input int id, input int sz);
        req_valid            = '0;
        req_valid[c]         = 1'b1;
        req_id[c*NBW +: NBW]      = NBW'(id);
        req_size_m1[c*NCW +: NCW] = NCW'(sz);
        cyc();
        req_valid = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [NC-1:0] g;
        int glog[$];

        reset_n     = 1'b0;
        req_valid   = 4'hF;
        req_id      = '0;
        req_size_m1 = '0;
        repeat (3) cyc();
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset_ready", 32'(req_ready), 32'd0);
        req_valid = '0;
        reset_n   = 1'b1;
        cyc();

        // Scenario 1: cores 0..3 arrive at barrier 3, size_m1=3.
        send(0, 3, 3);
        chk("s1_busy_after_first", 32'(busy), 32'd1);
        chk("s1_no_rsp_early", 32'(rsp_valid), 32'd0);
        send(1, 3, 3);
        send(2, 3, 3);
        chk("s1_no_rsp_third", 32'(rsp_valid), 32'd0);
        send(3, 3, 3);
        chk("s1_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("s1_rsp_id", 32'(rsp_id), 32'd3);
        chk("s1_busy_rsp_cycle", 32'(busy), 32'd1);
        cyc();
        chk("s1_rsp_one_cycle", 32'(rsp_valid), 32'd0);
        chk("s1_busy_done", 32'(busy), 32'd0);
`ifdef GBAR_PERF_EN
        chk("perf_releases", perf_releases, 32'd1);
        chk("perf_wait_cycles", perf_wait_cycles, 32'd4);
`endif

        // Scenario 2: all cores request barrier 1 at once; grants one per cycle.
        req_valid = 4'hF;
        for (int c = 0; c < NC; c++) begin
            req_id[c*NBW +: NBW]      = 3'd1;
            req_size_m1[c*NCW +: NCW] = 2'd3;
        end
        for (int n = 0; n < 8 && req_valid != '0; n++) begin
            @(negedge clk);
            g = req_ready;
            cyc();
            req_valid = req_valid & ~g;
            for (int c = 0; c < NC; c++) if (g[c]) glog.push_back(c);
            if (glog.size() == 3) chk("s2_no_rsp_third", 32'(rsp_valid), 32'd0);
        end
        chk("s2_grant_count", 32'(glog.size()), 32'd4);
        for (int k = 0; k < 4; k++)
            chk("s2_rr_order", (k < glog.size()) ? 32'(glog[k]) : 32'hFFFF_FFFF, 32'(k));
        chk("s2_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("s2_rsp_id", 32'(rsp_id), 32'd1);
        req_valid = '0;
        cyc();

        // Scenario 3: interleaved pairs on barriers 2 and 5.
        send(0, 2, 1);
        send(2, 5, 1);
        chk("s3_no_crosstalk", 32'(rsp_valid), 32'd0);
        send(1, 2, 1);
        chk("s3_rsp2_valid", 32'(rsp_valid), 32'd1);
        chk("s3_rsp2_id", 32'(rsp_id), 32'd2);
        send(3, 5, 1);
        chk("s3_rsp5_valid", 32'(rsp_valid), 32'd1);
        chk("s3_rsp5_id", 32'(rsp_id), 32'd5);
        cyc();
        chk("s3_idle", 32'(busy), 32'd0);

        // Scenario 4: duplicate arrival is idempotent.
        send(0, 4, 1);
        send(0, 4, 1);
        chk("s4_dup_no_rsp", 32'(rsp_valid), 32'd0);
        chk("s4_dup_busy", 32'(busy), 32'd1);
        send(1, 4, 1);
        chk("s4_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("s4_rsp_id", 32'(rsp_id), 32'd4);
        cyc();

        // Scenario 5: size_m1=0 releases at once; arrival during the pulse is fresh.
        send(2, 7, 0);
        chk("s5_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("s5_rsp_id", 32'(rsp_id), 32'd7);
        send(1, 7, 1);
        chk("s5_fresh_no_rsp", 32'(rsp_valid), 32'd0);
        send(3, 7, 1);
        chk("s5_fresh_rsp", 32'(rsp_valid), 32'd1);
        chk("s5_fresh_id", 32'(rsp_id), 32'd7);
        cyc();
        chk("s5_idle", 32'(busy), 32'd0);

        // Scenario 6: async reset mid-episode discards arrivals.
        send(0, 0, 2);
        send(1, 0, 2);
        chk("s6_busy_pending", 32'(busy), 32'd1);
        req_valid    = '0;
        req_valid[2] = 1'b1;
        req_id[2*NBW +: NBW]      = 3'd0;
        req_size_m1[2*NCW +: NCW] = 2'd2;
        #1;
        reset_n = 1'b0;
        #1;
        chk("s6_busy_async", 32'(busy), 32'd0);
        chk("s6_ready_in_reset", 32'(req_ready), 32'd0);
        cyc();
        req_valid = '0;
        reset_n   = 1'b1;
        cyc();
        chk("s6_no_rsp_after", 32'(rsp_valid), 32'd0);
        cyc();
        chk("s6_no_rsp_after2", 32'(rsp_valid), 32'd0);
        send(0, 0, 2);
        send(1, 0, 2);
        chk("s6_fresh_partial", 32'(rsp_valid), 32'd0);
        send(2, 0, 2);
        chk("s6_fresh_rsp", 32'(rsp_valid), 32'd1);
        chk("s6_fresh_id", 32'(rsp_id), 32'd0);
        cyc();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
